led_display_axil_slave: RTL and testbench
=========================================

// Module: led_display_axil_slave
// PURPOSE
//  AXI4-Lite slave register file for the led_display IP. It is the S00_AXI endpoint that the bus master writes and reads.
//  It holds four 32-bit read/write registers and drives the LED outputs from them, with an optional blink engine.
//  It sits between the interconnect (or VIP master) and the board LED pins.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  4   byte address width (4 regs x 4 B)
//  NUM_LEDS            8   LED output width; must be <= 32
// PORTS
//  s00_axi_aclk     in   1      sole clock
//  s00_axi_aresetn  in   1      asynchronous active-low reset
//  s00_axi_awaddr   in   4      write address
//  s00_axi_awprot   in   3      ignored
//  s00_axi_awvalid  in   1      write-address valid
//  s00_axi_awready  out  1      write-address ready
//  s00_axi_wdata    in   32     write data
//  s00_axi_wstrb    in   4      byte enables
//  s00_axi_wvalid   in   1      write-data valid
//  s00_axi_wready   out  1      write-data ready
//  s00_axi_bresp    out  2      always 2'b00 (OKAY)
//  s00_axi_bvalid   out  1      write response valid
//  s00_axi_bready   in   1      write response ready
//  s00_axi_araddr   in   4      read address
//  s00_axi_arprot   in   3      ignored
//  s00_axi_arvalid  in   1      read-address valid
//  s00_axi_arready  out  1      read-address ready
//  s00_axi_rdata    out  32     read data
//  s00_axi_rresp    out  2      always 2'b00 (OKAY)
//  s00_axi_rvalid   out  1      read data valid
//  s00_axi_rready   in   1      read data ready
//  led_o            out  NUM_LEDS  LED drive
// BEHAVIOUR
//  Reset (async, aresetn=0):
//   - REG0..REG3, all valids, all readies, rdata, led_o, blink counter = 0; blink phase = 1.
//   - rst_done flop sets 1 on the first clock edge after release; every ready is gated by rst_done.
//  Register map (decode addr[3:2]; addr[1:0] ignored):
//   - 0x0 PATTERN: led_o source.
//   - 0x4 CTRL: bit0 EN, bit1 BLINK.
//   - 0x8 PERIOD: blink half-period in cycles.
//   - 0xC SCRATCH.
//   - All four are fully R/W and read back exactly as written.
//  Write channel:
//   - AW and W are accepted independently into 1-deep holding slots.
//   - awready = rst_done & !aw_full; wready = rst_done & !w_full.
//   - Commit happens on the first edge where aw_full & w_full & !bvalid.
//     Register bytes are updated per wstrb; both slots clear; bvalid=1 from the next cycle.
//   - bvalid holds until bready & bvalid.
//   - Same-cycle AW+W handshake at edge N: commit at edge N+1, bvalid visible after N+1.
//   - W before AW (or AW before W) is legal; the early beat waits in its slot with its ready low.
//  Read channel:
//   - arready = rst_done & !rvalid.
//   - On AR handshake, rdata is registered from the current register value and rvalid=1 next cycle.
//   - rdata and rvalid hold until rready. Read latency is 1 cycle.
//  Simultaneous read and commit to the same register: the read returns the pre-commit value.
//  Read and write channels are fully concurrent; neither blocks the other.
//  LED output (registered, 1-cycle delay from the register change):
//   - EN=0: led_o = 0.
//   - EN=1, BLINK=0: led_o = PATTERN[NUM_LEDS-1:0].
//   - EN=1, BLINK=1: the counter increments each cycle. When cnt >= PERIOD, cnt<=0 and phase toggles.
//     led_o = phase ? PATTERN : 0. PERIOD=0 toggles phase every cycle.
//   - Any commit to PERIOD or CTRL resets cnt=0 and phase=1.
//   - A 32-bit counter has no wrap concern, since the compare uses >=.
//  Reset mid-transaction: the in-flight beat is dropped and no bvalid/rvalid is issued; the master must re-issue.
// STRUCTURE
//  Package led_display_pkg:
//   - register offset localparams (REG_PATTERN..REG_SCRATCH)
//   - CTRL bit indices
//   - AXI_RESP_OKAY constant
//   - reg-index typedef logic [1:0]
//  One sub-module, led_display_blinker: inputs are clk, rst_n, en, blink, period, pattern, restart; output is led_o.
// TESTING
//  1. Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back the same addresses -> rdata 1,2,3,4, all resp OKAY.
//  2. Write 0xAABBCCDD with wstrb=4'b0101 to SCRATCH (previously 0) -> read returns 0x00BB00DD.
//  3. Drive W 3 cycles before AW -> wready low after the W handshake, commit occurs only after AW; exactly one bvalid.
//  4. Hold bready=0 for 5 cycles after a write -> bvalid stays high, awready/wready stay low for the next write,
//     and the second write commits after the B handshake.
//  5. PATTERN=0x5A, PERIOD=3, CTRL=0x3 -> led_o alternates 0x5A / 0x00, each phase lasting 4 cycles; CTRL=0x1 -> steady 0x5A.
//  6. Assert aresetn=0 mid-read (rvalid=1) -> rvalid, led_o, and regs go to 0 immediately;
//     readies rise 1 cycle after release.

Source files
------------

// File: rtl/led_display_pkg.sv
// Shared constants for the led_display AXI4-Lite register block.
// Register offsets, CTRL bit positions and the OKAY response code.
package led_display_pkg;

    typedef logic [1:0] reg_idx_t;

    localparam logic [3:0] REG_PATTERN = 4'h0;
    localparam logic [3:0] REG_CTRL    = 4'h4;
    localparam logic [3:0] REG_PERIOD  = 4'h8;
    localparam logic [3:0] REG_SCRATCH = 4'hC;

    localparam reg_idx_t IDX_PATTERN = REG_PATTERN[3:2];
    localparam reg_idx_t IDX_CTRL    = REG_CTRL[3:2];
    localparam reg_idx_t IDX_PERIOD  = REG_PERIOD[3:2];
    localparam reg_idx_t IDX_SCRATCH = REG_SCRATCH[3:2];

    localparam int CTRL_EN    = 0;
    localparam int CTRL_BLINK = 1;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic reg_idx_t reg_idx(input logic [3:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/led_display_axil_slave_if.sv
// AXI4-Lite bus bundle between the interconnect master and the
// led_display register slave.
interface led_display_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid,
        output bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid,
        input  bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/led_display_blinker.sv
// LED drive stage: steady pattern or pattern gated by a half-period
// phase counter; restart realigns to the "on" phase.
module led_display_blinker #(
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                blink,
    input  logic [31:0]         period,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic                restart,
    output logic [NUM_LEDS-1:0] led_o
);

    logic [31:0] cnt;
    logic        phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b1;
            led_o <= '0;
        end else begin
            if (restart) begin
                cnt   <= '0;
                phase <= 1'b1;
            end else if (en && blink) begin
                if (cnt >= period) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end

            if (!en)
                led_o <= '0;
            else if (!blink)
                led_o <= pattern;
            else
                led_o <= phase ? pattern : '0;
        end
    end

endmodule

// File: rtl/led_display_axil_slave.sv
// AXI4-Lite slave holding PATTERN/CTRL/PERIOD/SCRATCH and driving LEDs.
// AW and W park in 1-deep slots; commit waits until B is free.
module led_display_axil_slave
    import led_display_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 8
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    led_display_axil_slave_if.slave s00_axi,
    output logic [NUM_LEDS-1:0]     led_o
);

    logic [31:0] regs [4];
    logic        rst_done;
    logic        aw_full;
    reg_idx_t    aw_idx;
    logic        w_full;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        bvalid;
    logic        rvalid;
    logic [31:0] rdata;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic restart;
    logic unused;

    assign s00_axi.awready = rst_done & ~aw_full;
    assign s00_axi.wready  = rst_done & ~w_full;
    assign s00_axi.arready = rst_done & ~rvalid;
    assign s00_axi.bvalid  = bvalid;
    assign s00_axi.bresp   = AXI_RESP_OKAY;
    assign s00_axi.rvalid  = rvalid;
    assign s00_axi.rdata   = rdata;
    assign s00_axi.rresp   = AXI_RESP_OKAY;

    assign aw_hs  = s00_axi.awvalid & s00_axi.awready;
    assign w_hs   = s00_axi.wvalid & s00_axi.wready;
    assign ar_hs  = s00_axi.arvalid & s00_axi.arready;
    assign commit = aw_full & w_full & ~bvalid;

    // Blink timing restarts whenever its control or period changes
    assign restart = commit &
        ((aw_idx == IDX_CTRL) | (aw_idx == IDX_PERIOD));

    assign unused = ^{s00_axi.awprot, s00_axi.arprot,
                      s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rst_done <= 1'b0;
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            rst_done <= 1'b1;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= reg_idx(s00_axi.awaddr);
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s00_axi.wdata;
                w_strb <= s00_axi.wstrb;
            end
            if (commit) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb[b])
                        regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
            end else if (bvalid && s00_axi.bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= regs[reg_idx(s00_axi.araddr)];
        end else if (rvalid && s00_axi.rready) begin
            rvalid <= 1'b0;
        end
    end

    led_display_blinker #(
        .NUM_LEDS (NUM_LEDS)
    ) u_blinker (
        .clk     (s00_axi_aclk),
        .rst_n   (s00_axi_aresetn),
        .en      (regs[IDX_CTRL][CTRL_EN]),
        .blink   (regs[IDX_CTRL][CTRL_BLINK]),
        .period  (regs[IDX_PERIOD]),
        .pattern (regs[IDX_PATTERN][NUM_LEDS-1:0]),
        .restart (restart),
        .led_o   (led_o)
    );

endmodule

// File: tb/tb_led_display_axil_slave.sv
// Scoreboard bench for led_display_axil_slave: directed writes/reads,
// strobes, channel skew, B back-pressure, blink timing and reset.
module tb_led_display_axil_slave;
    import led_display_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] led_o;

    int checks = 0;
    int errors = 0;
    int bcount = 0;

    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    led_display_axil_slave_if bus ();

    led_display_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_LEDS           (8)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (bus),
        .led_o           (led_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response on every B/R handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bvalid && bus.bready) begin
                bcount++;
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_b: got bvalid expected none");
                end else begin
                    chk("bresp", 32'(bus.bresp), 32'(bq.pop_front()));
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_r: got rvalid expected none");
                end else begin
                    logic [33:0] e;
                    e = rq.pop_front();
                    chk("rdata", bus.rdata, e[31:0]);
                    chk("rresp", 32'(bus.rresp), 32'(e[33:32]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] a);
        bit done = 0;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            done = bus.awready;
            step();
        end
        bus.awvalid = 1'b0;
        if (!done) chk("aw_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit done = 0;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            done = bus.wready;
            step();
        end
        bus.wvalid = 1'b0;
        if (!done) chk("w_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_ar(input logic [3:0] a);
        bit done = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            done = bus.arready;
            step();
        end
        bus.arvalid = 1'b0;
        if (!done) chk("ar_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_b();
        for (int n = 0; n < 100 && bq.size() != 0; n++) step();
        chk("b_pending", 32'(bq.size()), 32'd0);
    endtask

    task automatic wait_r();
        for (int n = 0; n < 100 && rq.size() != 0; n++) step();
        chk("r_pending", 32'(rq.size()), 32'd0);
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit wait_resp = 1);
        bq.push_back(AXI_RESP_OKAY);
        fork
            send_aw(a);
            send_w(d, s);
        join
        if (wait_resp) wait_b();
    endtask

    task automatic read(input logic [3:0] a, input logic [31:0] exp);
        rq.push_back({AXI_RESP_OKAY, exp});
        send_ar(a);
        wait_r();
    endtask

    initial begin
        int b0;
        rst_n       = 1'b0;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;

        repeat (3) step();
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_led", 32'(led_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_awready_low", 32'(bus.awready), 32'd0);
        step();
        chk("rel_awready", 32'(bus.awready), 32'd1);
        chk("rel_wready", 32'(bus.wready), 32'd1);
        chk("rel_arready", 32'(bus.arready), 32'd1);

        // basic write/readback of all four registers
        write(4'h0, 32'h1, 4'hF);
        write(4'h4, 32'h2, 4'hF);
        write(4'h8, 32'h3, 4'hF);
        write(4'hC, 32'h4, 4'hF);
        read(4'h0, 32'h1);
        read(4'h4, 32'h2);
        read(4'h8, 32'h3);
        read(4'hC, 32'h4);

        // byte strobes
        write(4'hC, 32'h0, 4'hF);
        write(4'hC, 32'hAABBCCDD, 4'b0101);
        read(4'hC, 32'h00BB00DD);

        // W three cycles ahead of AW
        b0 = bcount;
        bq.push_back(AXI_RESP_OKAY);
        send_w(32'h12345678, 4'hF);
        for (int i = 0; i < 3; i++) begin
            chk("early_w_wready", 32'(bus.wready), 32'd0);
            chk("early_w_bvalid", 32'(bus.bvalid), 32'd0);
            step();
        end
        send_aw(4'hC);
        wait_b();
        repeat (4) step();
        chk("early_w_bcount", 32'(bcount - b0), 32'd1);
        read(4'hC, 32'h12345678);

        // B back-pressure blocks the next commit
        bus.bready = 1'b0;
        write(4'h0, 32'h11, 4'hF, 0);
        repeat (2) step();
        write(4'h0, 32'h22, 4'hF, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", 32'(bus.bvalid), 32'd1);
            chk("bp_awready", 32'(bus.awready), 32'd0);
            chk("bp_wready", 32'(bus.wready), 32'd0);
            step();
        end
        read(4'h0, 32'h11);
        bus.bready = 1'b1;
        wait_b();
        read(4'h0, 32'h22);

        // blink: 4 cycles on, 4 cycles off
        write(4'h0, 32'h5A, 4'hF);
        write(4'h8, 32'h3, 4'hF);
        chk("blink_pre_led", 32'(led_o), 32'd0);
        fork
            write(4'h4, 32'h3, 4'hF, 0);
            begin
                bit seen = 0;
                for (int n = 0; n < 50 && !seen; n++) begin
                    seen = (led_o == 8'h5A);
                    if (!seen) step();
                end
                chk("blink_start", 32'(seen), 32'd1);
                for (int i = 0; i < 16; i++) begin
                    chk("blink_seq", 32'(led_o),
                        ((i / 4) % 2 == 0) ? 32'h5A : 32'h0);
                    step();
                end
            end
        join
        wait_b();
        write(4'h4, 32'h1, 4'hF);
        repeat (2) step();
        for (int i = 0; i < 6; i++) begin
            chk("steady_led", 32'(led_o), 32'h5A);
            step();
        end

        // reset while a read response is outstanding
        bus.rready = 1'b0;
        send_ar(4'h0);
        chk("mid_rvalid", 32'(bus.rvalid), 32'd1);
        chk("mid_rdata", bus.rdata, 32'h5A);
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("arst_led", 32'(led_o), 32'd0);
        chk("arst_arready", 32'(bus.arready), 32'd0);
        repeat (2) step();
        bus.rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel2_arready_low", 32'(bus.arready), 32'd0);
        step();
        chk("rel2_arready", 32'(bus.arready), 32'd1);
        chk("rel2_awready", 32'(bus.awready), 32'd1);
        chk("rel2_wready", 32'(bus.wready), 32'd1);
        read(4'h0, 32'h0);
        read(4'h4, 32'h0);
        read(4'h8, 32'h0);
        read(4'hC, 32'h0);
        chk("rel2_led", 32'(led_o), 32'd0);

        repeat (3) step();
        chk("end_bq", 32'(bq.size()), 32'd0);
        chk("end_rq", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
